// File: rtl/soc_map_pkg.sv
// SoC memory map shared by the bus decoders: default region table,
// region index names, decoder FSM states and a saturating counter helper.
package soc_map_pkg;

  localparam int unsigned MAP_NUM_REGIONS = 5;
  localparam int unsigned MAP_ADDR_W      = 32;

  localparam int unsigned REGION_BOOT_ROM = 0;
  localparam int unsigned REGION_CODE_RAM = 1;
  localparam int unsigned REGION_DATA_RAM = 2;
  localparam int unsigned REGION_GPIO     = 3;
  localparam int unsigned REGION_UART     = 4;

  // Element [i] is region i (leftmost entry is the highest index)
  localparam logic [MAP_NUM_REGIONS-1:0][MAP_ADDR_W-1:0] DEF_REGION_BASE = {
    32'hC000_1000,  // UART
    32'hC000_0000,  // GPIO
    32'h4000_0000,  // data RAM
    32'h0001_0000,  // code RAM
    32'h0000_0000   // boot ROM
  };

  localparam logic [MAP_NUM_REGIONS-1:0][MAP_ADDR_W-1:0] DEF_REGION_END = {
    32'hC000_1FFF,
    32'hC000_0FFF,
    32'h4000_3FFF,
    32'h0001_3FFF,
    32'h0000_3FFF
  };

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RSP,
    ERR_RSP
  } dec_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/addr_region_match.sv
// Combinational priority region decoder: reports whether an address falls in
// any [base, end] window and the lowest index of the windows that contain it.
module addr_region_match #(
  parameter int unsigned NUM_REGIONS = 5,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned IDX_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1,
  parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_BASE = '0,
  parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_END  = '0
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
);

  // Scan downwards so the lowest matching index is the last one written.
  // (addr - base) <= (end - base) is the unsigned window test in one compare:
  // addresses below base wrap to large values and fall outside.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int unsigned i = NUM_REGIONS; i > 0; i--) begin
      if ((addr - REGION_BASE[i-1]) <= (REGION_END[i-1] - REGION_BASE[i-1])) begin
        hit = 1'b1;
        idx = IDX_W'(i - 1);
      end
    end
  end

endmodule

// File: rtl/soc_addr_decoder.sv
// Core bus address decoder and response router: steers one master request to
// the matching slave, tracks the single outstanding transaction, and answers
// unmapped accesses and silent slaves with an error response.
module soc_addr_decoder
  import soc_map_pkg::*;
#(
  parameter int unsigned NUM_REGIONS    = MAP_NUM_REGIONS,
  parameter int unsigned ADDR_W         = MAP_ADDR_W,
  parameter int unsigned DATA_W         = 32,
  parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
  parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_END  = DEF_REGION_END,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          m_req,
  input  logic                          m_we,
  input  logic [ADDR_W-1:0]             m_addr,
  input  logic [DATA_W-1:0]             m_wdata,
  input  logic [DATA_W/8-1:0]           m_be,
  output logic                          m_gnt,
  output logic                          m_rvalid,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          m_err,
  output logic [NUM_REGIONS-1:0]        s_req,
  output logic                          s_we,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [DATA_W/8-1:0]           s_be,
  input  logic [NUM_REGIONS-1:0]        s_gnt,
  input  logic [NUM_REGIONS-1:0]        s_rvalid,
  input  logic [NUM_REGIONS*DATA_W-1:0] s_rdata,
  output logic [15:0]                   decode_err_cnt,
  output logic [15:0]                   timeout_cnt
);

  localparam int unsigned IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  dec_state_e        state;
  logic [IDX_W-1:0]  sel;
  logic [CNT_W-1:0]  wait_cnt;
  logic              dec_hit;
  logic [IDX_W-1:0]  dec_idx;
  logic              req_idle;
  logic              dec_gnt;
  logic              sel_rvalid;
  logic [DATA_W-1:0] sel_rdata;

  addr_region_match #(
    .NUM_REGIONS (NUM_REGIONS),
    .ADDR_W      (ADDR_W),
    .IDX_W       (IDX_W),
    .REGION_BASE (REGION_BASE),
    .REGION_END  (REGION_END)
  ) u_match (
    .addr (m_addr),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  assign s_we    = m_we;
  assign s_addr  = m_addr;
  assign s_wdata = m_wdata;
  assign s_be    = m_be;

  assign req_idle = rst_n && m_req && (state == IDLE);

  // Request path: only an IDLE request reaches a slave; a miss is granted locally
  always_comb begin
    s_req   = '0;
    dec_gnt = 1'b0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      if (dec_hit && (dec_idx == IDX_W'(i))) begin
        s_req[i] = req_idle;
        dec_gnt  = s_gnt[i];
      end
    end
    m_gnt = req_idle && (dec_hit ? dec_gnt : 1'b1);
  end

  // Response mux: pick valid and data of the slave owning the outstanding access
  always_comb begin
    sel_rvalid = 1'b0;
    sel_rdata  = '0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      if (sel == IDX_W'(i)) begin
        sel_rvalid = s_rvalid[i];
        sel_rdata  = s_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Transaction FSM with registered master response and error counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      sel            <= '0;
      wait_cnt       <= '0;
      m_rvalid       <= 1'b0;
      m_err          <= 1'b0;
      m_rdata        <= '0;
      decode_err_cnt <= '0;
      timeout_cnt    <= '0;
    end else begin
      m_rvalid <= 1'b0;
      m_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (req_idle && !dec_hit) begin
            m_rvalid       <= 1'b1;
            m_err          <= 1'b1;
            m_rdata        <= '0;
            decode_err_cnt <= sat_inc16(decode_err_cnt);
            state          <= ERR_RSP;
          end else if (req_idle && dec_gnt) begin
            sel      <= dec_idx;
            wait_cnt <= '0;
            state    <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (sel_rvalid) begin
            m_rvalid <= 1'b1;
            m_rdata  <= sel_rdata;
            state    <= IDLE;
          end else if (wait_cnt == WAIT_LIMIT) begin
            m_rvalid    <= 1'b1;
            m_err       <= 1'b1;
            m_rdata     <= '0;
            timeout_cnt <= sat_inc16(timeout_cnt);
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ERR_RSP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/soc_addr_decoder.md
Name: soc_addr_decoder

Overview:
- Parametrised address decoder and response router between one core data/instruction bus master port and NUM_REGIONS slave ports (boot ROM, code RAM, data RAM, GPIO, UART, future peripherals).
- Replaces hard-coded per-peripheral address compares.
- Tracks one outstanding transaction, returns a decode-error response for unmapped addresses, and times out slaves that never respond.
- Sits in the SoC top between the core's bus port and the peripheral/memory slaves.

Parameters:
- NUM_REGIONS, 5, number of slave ports/regions (1..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data width (multiple of 8).
- REGION_BASE, package default table, NUM_REGIONS x ADDR_W inclusive base addresses.
- REGION_END, package default table, NUM_REGIONS x ADDR_W inclusive end addresses.
- TIMEOUT_CYCLES, 255, response-wait cycles before timeout error (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m_req  in  1  master request, held until m_gnt
- m_we  in  1  write enable
- m_addr  in  ADDR_W  byte address
- m_wdata  in  DATA_W  write data
- m_be  in  DATA_W/8  byte enables
- m_gnt  out  1  request accepted (combinational)
- m_rvalid  out  1  response valid, one-cycle pulse (registered)
- m_rdata  out  DATA_W  read data (registered)
- m_err  out  1  response is error, qualified by m_rvalid
- s_req  out  NUM_REGIONS  one-hot slave request
- s_we, s_addr, s_wdata, s_be  out  1/ADDR_W/DATA_W/DATA_W/8  broadcast copies of master fields
- s_gnt  in  NUM_REGIONS  per-slave grant
- s_rvalid  in  NUM_REGIONS  per-slave response valid
- s_rdata  in  NUM_REGIONS*DATA_W  per-slave read data, slave i at [i*DATA_W +: DATA_W]
- decode_err_cnt  out  16  saturating count of unmapped accesses
- timeout_cnt  out  16  saturating count of slave timeouts

Behaviour:
- Reset (async on rst_n low):
  - state=IDLE; m_rvalid=0, m_err=0, m_rdata=0.
  - Counters 0; sel index 0; wait counter 0.
- Decode (combinational on m_addr):
  - Region i hits when REGION_BASE[i] <= m_addr <= REGION_END[i], unsigned.
  - Overlapping regions: lowest index wins.
  - No hit: miss.
- FSM states: IDLE, WAIT_RSP, ERR_RSP.
- IDLE:
  - m_req=1 and hit i: s_req[i]=1 in the same cycle, all other s_req=0; m_gnt=s_gnt[i].
  - On s_gnt[i]: latch sel=i, clear wait counter, go to WAIT_RSP.
  - m_req=1 and miss: m_gnt=1 same cycle, no s_req; go to ERR_RSP; decode_err_cnt++ (saturate at 0xFFFF).
- WAIT_RSP:
  - m_gnt=0 and s_req=0; new master requests stall.
  - s_rvalid[sel]=1: next cycle m_rvalid=1, m_err=0, m_rdata=s_rdata[sel]; go to IDLE.
  - Otherwise wait counter++. When it reaches TIMEOUT_CYCLES with no response: next cycle m_rvalid=1, m_err=1, m_rdata=0; timeout_cnt++ (saturating); go to IDLE.
  - s_rvalid[sel] in the same cycle the counter hits the limit: the response wins, no timeout.
- ERR_RSP: m_rvalid=1, m_err=1, m_rdata=0 for one cycle; go to IDLE.
- Response latency:
  - m_rvalid is asserted exactly 1 cycle after s_rvalid[sel].
  - Decode-error response: 1 cycle after the miss grant.
- Back-to-back requests: a new request may be granted in the IDLE cycle concurrent with m_rvalid.
- Stray responses: s_rvalid from non-selected slaves, or any s_rvalid in IDLE/ERR_RSP, is ignored (including late responses after a timeout).
- Writes: the response path is identical to reads; m_rdata=0 on write responses is not required (slave data is passed through).
- m_rvalid is a single-cycle pulse.
- m_rdata holds its value between pulses.

Decomposition:
- Package soc_map_pkg:
  - Default REGION_BASE/REGION_END arrays for boot ROM 0x0000_0000–0x0000_3FFF, code RAM 0x0001_0000–0x0001_3FFF, data RAM 0x4000_0000–0x4000_3FFF, GPIO 0xC000_0000–0xC000_0FFF, UART 0xC000_1000–0xC000_1FFF.
  - Region index constants and the FSM state enum.
- Sub-module addr_region_match: pure combinational priority decoder (hit, index) shared with the instruction-side port.

Test Plan:
1. Read 0x4000_0010, data RAM grants immediately and responds after 2 cycles with 0xDEADBEEF -> s_req=5'b00100, m_rvalid one cycle after s_rvalid, m_rdata=0xDEADBEEF, m_err=0.
2. Access 0x2000_0000 (unmapped) -> m_gnt same cycle, no s_req, next cycle m_rvalid=1/m_err=1/m_rdata=0, decode_err_cnt=1.
3. UART at 0xC000_1004 never asserts s_rvalid, TIMEOUT_CYCLES=8 -> m_err pulse 9 cycles after grant, timeout_cnt=1; a late UART s_rvalid is ignored.
4. GPIO withholds s_gnt for 3 cycles with m_req held -> s_req[3] stays high, m_gnt rises with s_gnt, single response returned.
5. Reset asserted in WAIT_RSP -> all outputs 0 immediately, FSM in IDLE, the next request is decoded normally.
6. Boundary addresses 0x0000_3FFF, 0x0000_4000, 0xC000_0FFF, 0xC000_1000 -> ROM hit, miss, GPIO hit, UART hit respectively.
